// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus (CDB).
// Up to one producer is granted per cycle. The granted result is broadcast on
// registered outputs one cycle later, tagged with the producer index.
//
// Ports:
//   clk, rst         rising-edge clock; asynchronous active-high reset
//   cdb_enable       0 holds the bus off, so no grants are issued
//   src_request      per-producer request, bit i = producer i
//   src_data         producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_accepted     combinational one-hot grant, forced to 0 during reset
//   cdb_out_valid    registered broadcast valid
//   cdb_out_tag      registered index of the granted producer
//   cdb_out_data     registered data of the granted producer
//   stall_count      (only with CDB_ARBITER_STALL_COUNT_EN) saturating count of
//                    cycles in which a requesting source was not granted
//
// Optional feature macro: CDB_ARBITER_STALL_COUNT_EN
module cdb_arbiter #(
    parameter int unsigned NUM_SOURCES   = 4,
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned CDB_TAG_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cdb_enable,
    input  logic [NUM_SOURCES-1:0]            src_request,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SOURCES-1:0]            src_accepted,
    output logic                              cdb_out_valid,
    output logic [CDB_TAG_WIDTH-1:0]          cdb_out_tag,
`ifdef CDB_ARBITER_STALL_COUNT_EN
    output logic [DATA_WIDTH-1:0]             cdb_out_data,
    output logic [7:0]                        stall_count
`else
    output logic [DATA_WIDTH-1:0]             cdb_out_data
`endif
);

    localparam int unsigned STALL_W = 8;

    logic [CDB_TAG_WIDTH-1:0] last_grant;
    logic [NUM_SOURCES-1:0]   hi_req_c;
    logic [NUM_SOURCES-1:0]   pick_c;
    logic [CDB_TAG_WIDTH-1:0] winner_c;
    logic [DATA_WIDTH-1:0]    win_data_c;
    logic                     any_grant_c;

    // Round-robin pick: the lowest requester above last_grant wins, otherwise
    // the search wraps and the lowest requester overall wins.
    always_comb begin
        hi_req_c = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (CDB_TAG_WIDTH'(i) > last_grant) begin
                hi_req_c[i] = src_request[i];
            end
        end
        pick_c = (|hi_req_c) ? hi_req_c : src_request;

        winner_c = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (pick_c[i]) begin
                winner_c = CDB_TAG_WIDTH'(i);
            end
        end

        any_grant_c  = cdb_enable && !rst && (|src_request);
        src_accepted = '0;
        win_data_c   = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (any_grant_c && (winner_c == CDB_TAG_WIDTH'(i))) begin
                src_accepted[i] = 1'b1;
                win_data_c      = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Broadcast register. Tag, data and pointer hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_out_valid <= 1'b0;
            cdb_out_tag   <= '0;
            cdb_out_data  <= '0;
            last_grant    <= CDB_TAG_WIDTH'(NUM_SOURCES - 1);
        end else begin
            cdb_out_valid <= any_grant_c;
            if (any_grant_c) begin
                cdb_out_tag  <= winner_c;
                cdb_out_data <= win_data_c;
                last_grant   <= winner_c;
            end
        end
    end

`ifdef CDB_ARBITER_STALL_COUNT_EN
    // A stall is counted when some requesting source is left ungranted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if ((|(src_request & ~src_accepted)) &&
                     (stall_count != {STALL_W{1'b1}})) begin
            stall_count <= stall_count + STALL_W'(1);
        end
    end
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates access to the common data bus (CDB) among NUM_SOURCES producers, e.g. ALU reservation stations.
- Each producer raises a request with its result. The arbiter accepts at most one per cycle using round-robin priority.
- The accepted result is broadcast on the registered CDB outputs one cycle later, tagged with the producer's index, for all listeners.

Parameters:
- NUM_SOURCES, 4, number of producer ports; 2..2**CDB_TAG_WIDTH.
- DATA_WIDTH, 4, bitwidth of a data word.
- CDB_TAG_WIDTH, 4, bitwidth of CDB tag; tag value = producer index.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cdb_enable  input  1  when 0, no grants are issued (bus held off).
- src_request  input  NUM_SOURCES  per-producer request, bit i = producer i.
- src_data  input  NUM_SOURCES*DATA_WIDTH  producer i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_accepted  output  NUM_SOURCES  combinational one-hot grant; the producer drops its request next cycle.
- cdb_out_valid  output  1  registered broadcast valid.
- cdb_out_tag  output  CDB_TAG_WIDTH  registered index of the granted producer.
- cdb_out_data  output  DATA_WIDTH  registered data of the granted producer.

Behaviour:
- Reset (async, rst=1): cdb_out_valid=0, cdb_out_tag=0, cdb_out_data=0, last_grant=NUM_SOURCES-1. src_accepted is forced to 0 while rst=1.
- Grant logic is combinational in cycle N:
  - If cdb_enable=1 and any src_request bit is set, exactly one src_accepted bit goes high.
  - The winner is the first requesting index found searching from last_grant+1 upward, wrapping modulo NUM_SOURCES.
  - src_accepted is always zero or one-hot, and is never set for a non-requesting source.
  - The only combinational paths to src_accepted are from src_request, cdb_enable, rst and state.
- Handshake: a request is consumed exactly in the cycle its src_accepted bit is 1. The producer must not assume acceptance otherwise, and src_data must be stable while src_request=1.
- Broadcast latency is 1 cycle. At the clk edge ending cycle N:
  - If a grant occurred: cdb_out_valid<=1, cdb_out_tag<=winner index (zero-extended), cdb_out_data<=winner's src_data, last_grant<=winner.
  - If no grant occurred: cdb_out_valid<=0, and tag, data and last_grant hold their previous values.
- Back-to-back grants are allowed every cycle; the bus has no bubble requirement.
- A source whose request persists after grant competes again; round-robin guarantees each requester is served within NUM_SOURCES grants.
- Boundary conditions:
  - No requests: no grant, valid drops next cycle.
  - Single requester: granted every cycle regardless of pointer.
  - Pointer at NUM_SOURCES-1: search wraps to 0.
  - cdb_enable=0 with pending requests: no grants, last_grant unchanged, valid=0 next cycle.
  - rst asserted mid-broadcast: outputs clear immediately (asynchronously), and the pending transfer is lost.
  - rst deassert: the first grant favours source 0.

Optional Feature:
- Macro: CDB_ARBITER_STALL_COUNT_EN.
- With the macro defined:
  - Adds output stall_count (width 8), reset to 0.
  - stall_count increments by 1 each cycle in which at least one src_request bit is set but that source is not granted, including cycles with cdb_enable=0.
  - stall_count saturates at 255 (no wrap).
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 with src_request=4'b1111 -> src_accepted=0, cdb_out_valid=0, tag=0, data=0. Release rst, same requests -> src_accepted=4'b0001; next cycle valid=1, tag=0, data=src_data[0].
- Round-robin: src_request held at 4'b1111, data i = i+5 -> grants 0,1,2,3,0 on consecutive cycles. cdb_out_tag lags by 1 cycle, data 5,6,7,8,5.
- Wrap and skip: last_grant=2, src_request=4'b0011 -> grant source 0; next cycle with the same requests -> grant source 1.
- Hold-off: cdb_enable=0 for 3 cycles with src_request=4'b0100 -> src_accepted=0, valid=0. Set cdb_enable=1 -> grant source 2, then valid=1, tag=2 one cycle later.
- Async reset mid-stream: assert rst between edges while cdb_out_valid=1 -> valid drops to 0 before the next edge. After release, the first grant goes to the lowest requesting index.
- With CDB_ARBITER_STALL_COUNT_EN defined: src_request=4'b0011 for 10 cycles -> stall_count=10. Force 300 contention cycles -> stall_count=255.
